// File: rtl/core_ldst_multiple_seq.sv
// LDM/STM sequencer: expands a decoded block transfer into word transfers.
// Ports: start/base/rn/reg_list/mode bits in, mem_* handshake, wb/done flags out.
module core_ldst_multiple_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base,
  input  logic [3:0]  rn,
  input  logic [15:0] reg_list,
  input  logic        increment,
  input  logic        pre_indexed,
  input  logic        load,
  input  logic        writeback,
  input  logic        user_regs,
  input  logic        restore_spsr,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  input  logic        mem_ready,
  output logic [3:0]  xfer_reg,
  output logic        xfer_user,
  output logic        wb_valid,
  output logic [31:0] wb_value,
  output logic        done,
  output logic        pc_loaded,
  output logic        spsr_restore
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FINISH
  } state_t;

  state_t      state;
  logic [15:0] rem;
  logic        fin_wb;
  logic        fin_pc;
  logic        fin_sp;
  logic [31:0] fin_val;

  logic [4:0]  cnt;
  logic [31:0] span;
  logic [31:0] base_al;
  logic [31:0] start_addr;
  logic [31:0] wb_calc;
  logic [15:0] rem_next;

  function automatic logic [4:0] popcnt(
    input logic [15:0] v
  );
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++)
      c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest(
    input logic [15:0] v
  );
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Empty list still spans 16 words.
  always_comb begin
    cnt     = popcnt(reg_list);
    span    = (reg_list == '0) ? 32'd64
                               : {25'd0, cnt, 2'b00};
    base_al = {base[31:2], 2'b00};
    start_addr = base_al;
    unique case ({increment, pre_indexed})
      2'b10:   start_addr = base_al;
      2'b11:   start_addr = base_al + 32'd4;
      2'b00:   start_addr = base_al - span + 32'd4;
      default: start_addr = base_al - span;
    endcase
    wb_calc  = increment ? base + span : base - span;
    // Drop the lowest set bit.
    rem_next = rem & (rem - 16'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      fin_wb       <= 1'b0;
      fin_pc       <= 1'b0;
      fin_sp       <= 1'b0;
      fin_val      <= '0;
      busy         <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      xfer_reg     <= '0;
      xfer_user    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_value     <= '0;
      done         <= 1'b0;
      pc_loaded    <= 1'b0;
      spsr_restore <= 1'b0;
    end else begin
      done         <= 1'b0;
      wb_valid     <= 1'b0;
      wb_value     <= '0;
      pc_loaded    <= 1'b0;
      spsr_restore <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            rem     <= reg_list;
            // A loaded Rn overrides the writeback.
            fin_wb  <= writeback
                       && !(load && reg_list[rn]);
            fin_pc  <= load && reg_list[15];
            fin_sp  <= restore_spsr;
            fin_val <= wb_calc;
            if (reg_list == '0) begin
              state        <= FINISH;
              done         <= 1'b1;
              wb_valid     <= writeback;
              wb_value     <= wb_calc;
              spsr_restore <= restore_spsr;
            end else begin
              state     <= XFER;
              mem_req   <= 1'b1;
              mem_addr  <= start_addr;
              xfer_reg  <= lowest(reg_list);
              mem_write <= !load;
              xfer_user <= user_regs;
            end
          end
        end
        XFER: begin
          if (mem_ready) begin
            rem <= rem_next;
            if (rem_next == '0) begin
              state        <= FINISH;
              mem_req      <= 1'b0;
              mem_addr     <= '0;
              xfer_reg     <= '0;
              mem_write    <= 1'b0;
              xfer_user    <= 1'b0;
              done         <= 1'b1;
              wb_valid     <= fin_wb;
              wb_value     <= fin_val;
              pc_loaded    <= fin_pc;
              spsr_restore <= fin_sp;
            end else begin
              mem_addr <= mem_addr + 32'd4;
              xfer_reg <= lowest(rem_next);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_ldst_multiple_seq.sv
// Bench for core_ldst_multiple_seq: queue-based reference model,
// per-cycle compare, directed literal cases and random traffic.
module tb_core_ldst_multiple_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [3:0]  rn = '0;
  logic [15:0] reg_list = '0;
  logic        increment = 1'b0;
  logic        pre_indexed = 1'b0;
  logic        load = 1'b0;
  logic        writeback = 1'b0;
  logic        user_regs = 1'b0;
  logic        restore_spsr = 1'b0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  xfer_reg;
  logic        xfer_user;
  logic        wb_valid;
  logic [31:0] wb_value;
  logic        done;
  logic        pc_loaded;
  logic        spsr_restore;

  core_ldst_multiple_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base(base), .rn(rn), .reg_list(reg_list),
    .increment(increment),
    .pre_indexed(pre_indexed),
    .load(load), .writeback(writeback),
    .user_regs(user_regs),
    .restore_spsr(restore_spsr),
    .busy(busy), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_ready(mem_ready), .xfer_reg(xfer_reg),
    .xfer_user(xfer_user), .wb_valid(wb_valid),
    .wb_value(wb_value), .done(done),
    .pc_loaded(pc_loaded),
    .spsr_restore(spsr_restore)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  r;
  } xf_t;

  xf_t         q[$];
  logic        fin_due = 1'b0;
  logic        e_write, e_user, e_wbv, e_pc, e_sp;
  logic [31:0] e_wbval, e_base;
  bit          chk_en = 0;
  logic        m_busy, m_nxt;

  function automatic int pop16(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_accept(output logic empty);
    int          n;
    logic [31:0] span, a, nx;
    n    = pop16(reg_list);
    span = (n == 0) ? 32'd64 : 32'(n * 4);
    a    = base & 32'hFFFF_FFFC;
    if (increment) nx = pre_indexed ? a + 4 : a;
    else nx = pre_indexed ? a - span : a - span + 4;
    for (int i = 0; i < 16; i++)
      if (reg_list[i]) begin
        q.push_back('{addr: nx, r: 4'(i)});
        nx += 4;
      end
    e_wbval = increment ? base + span : base - span;
    e_wbv   = writeback && !(load && reg_list[rn]);
    e_pc    = load && reg_list[15];
    e_sp    = restore_spsr;
    e_write = !load;
    e_user  = user_regs;
    e_base  = base;
    empty   = (n == 0);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      m_busy = (q.size() > 0) || fin_due;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_req", 32'(mem_req), 32'(q.size() > 0));
      chk("done", 32'(done), 32'(fin_due));
      if (mem_req && q.size() > 0) begin
        chk("mem_addr", mem_addr, q[0].addr);
        chk("xfer_reg", 32'(xfer_reg), 32'(q[0].r));
        chk("mem_write", 32'(mem_write), 32'(e_write));
        chk("xfer_user", 32'(xfer_user), 32'(e_user));
      end
      if (done && fin_due) begin
        chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
        if (e_base[1:0] == 2'b00)
          chk("wb_value", wb_value, e_wbval);
        chk("pc_loaded", 32'(pc_loaded), 32'(e_pc));
        chk("spsr_restore", 32'(spsr_restore), 32'(e_sp));
      end else begin
        chk("wb_valid_idle", 32'(wb_valid), 32'd0);
      end
      m_nxt = 1'b0;
      if (q.size() > 0 && mem_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_nxt = 1'b1;
      end
      if (!m_busy && start) model_accept(m_nxt);
      fin_due = m_nxt;
    end
  end

  // ---------------- observation log ----------------
  logic [31:0] obs_a[$];
  logic [3:0]  obs_r[$];
  logic        obs_w[$];
  int          req_cyc;
  logic        done_seen;
  int          done_cyc;
  logic        d_wbv, d_pc, d_sp;
  logic [31:0] d_wbval;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        req_cyc++;
        if (mem_ready) begin
          obs_a.push_back(mem_addr);
          obs_r.push_back(xfer_reg);
          obs_w.push_back(mem_write);
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        d_wbv     = wb_valid;
        d_wbval   = wb_value;
        d_pc      = pc_loaded;
        d_sp      = spsr_restore;
      end
    end
  end

  task automatic clear_obs();
    obs_a.delete();
    obs_r.delete();
    obs_w.delete();
    req_cyc   = 0;
    done_seen = 1'b0;
    done_cyc  = 0;
  endtask

  task automatic issue(input logic [31:0] b,
                       input logic [3:0] r,
                       input logic [15:0] l,
                       input logic inc, pre, ld,
                       input logic wb, usr, rs,
                       output int t);
    int g = 0;
    @(posedge clk); #1;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (busy) chk("issue_wait", 32'(busy), 32'd0);
    base = b; rn = r; reg_list = l;
    increment = inc; pre_indexed = pre;
    load = ld; writeback = wb;
    user_regs = usr; restore_spsr = rs;
    start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done_seen && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic chk_xf(input string nm, input int i,
                        input logic [31:0] a,
                        input logic [3:0] r);
    if (obs_a.size() > i) begin
      chk({nm, "_addr"}, obs_a[i], a);
      chk({nm, "_reg"}, 32'(obs_r[i]), 32'(r));
    end else begin
      chk({nm, "_present"}, 32'(obs_a.size()), 32'(i + 1));
    end
  endtask

  task automatic ldmia_r1r3(input string nm);
    int t;
    clear_obs();
    mem_ready = 1'b1;
    issue(32'h1000, 4'd0, 16'h000A,
          1, 0, 1, 0, 0, 0, t);
    wait_done();
    chk({nm, "_n"}, 32'(obs_a.size()), 32'd2);
    chk_xf(nm, 0, 32'h1000, 4'd1);
    chk_xf(nm, 1, 32'h1004, 4'd3);
    chk({nm, "_lat"}, 32'(done_cyc - t), 32'd3);
    chk({nm, "_wbv"}, 32'(d_wbv), 32'd0);
  endtask

  initial begin
    int t;
    int g;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl",
        32'({busy, mem_req, mem_write, xfer_user,
             wb_valid, done, pc_loaded, spsr_restore,
             xfer_reg}), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wbval", wb_value, 32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1;

    ldmia_r1r3("ldmia");

    // STMDB! r13, {r4,r5,r6,lr}
    clear_obs();
    mem_ready = 1'b1;
    issue(32'h2000, 4'd13, 16'h4070,
          0, 1, 0, 1, 0, 0, t);
    wait_done();
    chk("stmdb_n", 32'(obs_a.size()), 32'd4);
    chk_xf("stmdb0", 0, 32'h1FF0, 4'd4);
    chk_xf("stmdb1", 1, 32'h1FF4, 4'd5);
    chk_xf("stmdb2", 2, 32'h1FF8, 4'd6);
    chk_xf("stmdb3", 3, 32'h1FFC, 4'd14);
    if (obs_w.size() > 0)
      chk("stmdb_wr", 32'(obs_w[0]), 32'd1);
    chk("stmdb_wbv", 32'(d_wbv), 32'd1);
    chk("stmdb_wbval", d_wbval, 32'h1FF0);

    // LDMIB {r0} with three stall cycles
    clear_obs();
    mem_ready = 1'b0;
    issue(32'h100, 4'd1, 16'h0001,
          1, 1, 1, 0, 0, 0, t);
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
    wait_done();
    chk("ldmib_reqcyc", 32'(req_cyc), 32'd4);
    chk("ldmib_n", 32'(obs_a.size()), 32'd1);
    chk_xf("ldmib", 0, 32'h104, 4'd0);
    chk("ldmib_lat", 32'(done_cyc - t), 32'd5);

    // LDMDA! r2, {r2,pc}^
    clear_obs();
    issue(32'h40, 4'd2, 16'h8004,
          0, 0, 1, 1, 0, 1, t);
    wait_done();
    chk_xf("ldmda0", 0, 32'h3C, 4'd2);
    chk_xf("ldmda1", 1, 32'h40, 4'd15);
    chk("ldmda_wbv", 32'(d_wbv), 32'd0);
    chk("ldmda_pc", 32'(d_pc), 32'd1);
    chk("ldmda_sp", 32'(d_sp), 32'd1);

    // Empty list, IA with writeback
    clear_obs();
    issue(32'h0, 4'd3, 16'h0000,
          1, 0, 1, 1, 0, 0, t);
    wait_done();
    chk("empty_req", 32'(req_cyc), 32'd0);
    chk("empty_lat", 32'(done_cyc - t), 32'd1);
    chk("empty_wbv", 32'(d_wbv), 32'd1);
    chk("empty_wbval", d_wbval, 32'h40);

    // Unaligned base: address low bits forced to zero
    clear_obs();
    issue(32'h1003, 4'd0, 16'h000A,
          1, 0, 1, 0, 0, 0, t);
    wait_done();
    chk_xf("unal0", 0, 32'h1000, 4'd1);
    chk_xf("unal1", 1, 32'h1004, 4'd3);

    // Reset during the second of four transfers
    clear_obs();
    mem_ready = 1'b1;
    issue(32'h3000, 4'd0, 16'h000F,
          1, 0, 0, 1, 0, 0, t);
    @(posedge clk);
    chk_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl",
        32'({busy, mem_req, mem_write, xfer_user,
             wb_valid, done, pc_loaded, spsr_restore,
             xfer_reg}), 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_wbval", wb_value, 32'd0);
    q.delete();
    fin_due = 1'b0;
    done_seen = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1;
    repeat (5) @(posedge clk);
    chk("abort_no_done", 32'(done_seen), 32'd0);
    ldmia_r1r3("post_abort");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      base = $urandom;
      rn = 4'($urandom);
      if ($urandom_range(0, 7) == 0) reg_list = '0;
      else if ($urandom_range(0, 1) == 0)
        reg_list = 16'($urandom) & 16'($urandom);
      else reg_list = 16'($urandom);
      increment = 1'($urandom);
      pre_indexed = 1'($urandom);
      load = 1'($urandom);
      writeback = 1'($urandom);
      user_regs = 1'($urandom);
      restore_spsr = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    mem_ready = 1'b1;
    g = 0;
    while (busy && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_idle", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
